// File: rtl/demux8_router.sv
// rtl/demux8_router.sv - 1-to-8 valid/ready demultiplexer with one holding register per channel
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data, in_sel      input word and its destination channel (0..7)
//   in_valid, in_ready   input handshake; in_ready depends only on in_sel and channel state
//   out0..out7           per-channel holding registers
//   out_valid, out_ready per-channel handshake, bit i belongs to channel i
//   xfer_count           accepted input transfers, wraps modulo 2^CW

module demux8_router #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic [2:0]    in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out0,
    output logic [N-1:0]  out1,
    output logic [N-1:0]  out2,
    output logic [N-1:0]  out3,
    output logic [N-1:0]  out4,
    output logic [N-1:0]  out5,
    output logic [N-1:0]  out6,
    output logic [N-1:0]  out7,
    output logic [7:0]    out_valid,
    input  logic [7:0]    out_ready,
    output logic [CW-1:0] xfer_count
);

    logic [N-1:0]  data_q [8];
    logic [7:0]    full_q;
    logic [CW-1:0] count_q;
    logic          accept;

    // A full channel can still take a word when its consumer drains on the
    // same edge, which gives one word per cycle through a flowing channel.
    // in_valid is deliberately not part of this term.
    assign in_ready = !full_q[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                // Load wins over drain so a simultaneous drain+load keeps the flag set.
                if (accept && (in_sel == i[2:0])) begin
                    data_q[i] <= in_data;
                    full_q[i] <= 1'b1;
                end else if (full_q[i] && out_ready[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
            if (accept) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign out0       = data_q[0];
    assign out1       = data_q[1];
    assign out2       = data_q[2];
    assign out3       = data_q[3];
    assign out4       = data_q[4];
    assign out5       = data_q[5];
    assign out6       = data_q[6];
    assign out7       = data_q[7];
    assign out_valid  = full_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_demux8_router.sv
// tb/tb_demux8_router.sv - directed table-driven bench for demux8_router

module tb_demux8_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] xfer_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux8_router #(.N(32), .CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (o0),
        .out1       (o1),
        .out2       (o2),
        .out3       (o3),
        .out4       (o4),
        .out5       (o5),
        .out6       (o6),
        .out7       (o7),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  sel;
        logic [31:0] data;
        logic [7:0]  ordy;
        logic        exp_rdy;
        logic [7:0]  exp_ov;
        logic [15:0] exp_cnt;
        logic [2:0]  ch;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] s,
                                input logic [31:0] d, input logic [7:0] orr,
                                input logic er, input logic [7:0] eov,
                                input logic [15:0] ec, input logic [2:0] c,
                                input logic [31:0] ed);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.data = d; t.ordy = orr;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_cnt = ec; t.ch = c; t.exp_d = ed;
        return t;
    endfunction

    function automatic logic [31:0] get_out(input logic [2:0] c);
        case (c)
            3'd0: return o0;
            3'd1: return o1;
            3'd2: return o2;
            3'd3: return o3;
            3'd4: return o4;
            3'd5: return o5;
            3'd6: return o6;
            default: return o7;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, probe in_ready before the rising edge,
    // sample registered outputs 1 time unit after it.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst       = v.rst;
        in_valid  = v.vld;
        in_sel    = v.sel;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, v.exp_rdy});
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {24'd0, out_valid}, {24'd0, v.exp_ov});
        chk({tag, ".xfer_count"}, {16'd0, xfer_count}, {16'd0, v.exp_cnt});
        chk($sformatf("%s.out%0d", tag, v.ch), get_out(v.ch), v.exp_d);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = 8'h00;
        repeat (2) @(posedge clk);

        // Reset held two cycles against an active producer and consumers
        vq.push_back(mk(1, 1, 3'd2, 32'h11, 8'hFF, 1, 8'h00, 16'd0, 3'd2, 32'h0));
        vq.push_back(mk(1, 1, 3'd5, 32'h12, 8'hFF, 1, 8'h00, 16'd0, 3'd5, 32'h0));
        // Idle probe of in_ready and zeroed data on every channel
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0, 0, 3'(i), 32'h0, 8'h00, 1, 8'h00, 16'd0, 3'(i), 32'h0));
        // Routing sweep with all consumers stalled
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0, 1, 3'(i), 32'hA0 + i, 8'h00, 1, 8'((1 << (i + 1)) - 1),
                            16'(i + 1), 3'(i), 32'hA0 + i));
        vq.push_back(mk(0, 1, 3'd3, 32'hDEAD, 8'h00, 0, 8'hFF, 16'd8, 3'd3, 32'hA3));
        // Drain everything except channels 0 and 5
        vq.push_back(mk(0, 0, 3'd0, 32'h0, 8'hDE, 0, 8'h21, 16'd8, 3'd5, 32'hA5));
        // Drain and reload channel 5 on one edge
        vq.push_back(mk(0, 1, 3'd5, 32'h55, 8'h20, 1, 8'h21, 16'd9, 3'd5, 32'h55));
        // Back-pressure for three cycles, then release
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0, 1, 3'd5, 32'h66, 8'h00, 0, 8'h21, 16'd9, 3'd5, 32'h55));
        vq.push_back(mk(0, 1, 3'd5, 32'h66, 8'h20, 1, 8'h21, 16'd10, 3'd5, 32'h66));
        // Independence: channel 0 stalled, channel 7 loads and drains
        vq.push_back(mk(0, 1, 3'd7, 32'hBEEF, 8'h80, 1, 8'hA1, 16'd11, 3'd7, 32'hBEEF));
        vq.push_back(mk(0, 0, 3'd7, 32'h0, 8'h80, 1, 8'h21, 16'd11, 3'd7, 32'hBEEF));
        vq.push_back(mk(0, 0, 3'd0, 32'h0, 8'h00, 0, 8'h21, 16'd11, 3'd0, 32'hA0));
        // out_ready on an empty channel has no effect
        vq.push_back(mk(0, 0, 3'd1, 32'h0, 8'h02, 1, 8'h21, 16'd11, 3'd1, 32'hA1));
        // Reset wins over a simultaneous accept
        vq.push_back(mk(1, 1, 3'd6, 32'h77, 8'h00, 1, 8'h00, 16'd0, 3'd6, 32'h0));
        vq.push_back(mk(0, 0, 3'd5, 32'h0, 8'h00, 1, 8'h00, 16'd0, 3'd5, 32'h0));

        foreach (vq[k]) step(vq[k], $sformatf("vec%0d", k));

        // Streaming into channel 2 with its consumer always ready
        for (int k = 1; k <= 10; k++)
            step(mk(0, 1, 3'd2, 32'(k), 8'h04, 1, 8'h04, 16'(k), 3'd2, 32'(k)),
                 $sformatf("stream%0d", k));

        // Run the counter up to all-ones, then wrap
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h5A5A; out_ready = 8'h04;
        repeat (65525) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("count_ffff", {16'd0, xfer_count}, 32'h0000FFFF);
        step(mk(0, 1, 3'd2, 32'h5B5B, 8'h04, 1, 8'h04, 16'd0, 3'd2, 32'h5B5B), "wrap");

        // Reset while channels 1 and 4 hold words and channel 6 is being loaded
        step(mk(0, 1, 3'd1, 32'h101, 8'h00, 1, 8'h06, 16'd1, 3'd1, 32'h101), "load1");
        step(mk(0, 1, 3'd4, 32'h104, 8'h00, 1, 8'h16, 16'd2, 3'd4, 32'h104), "load4");
        step(mk(1, 1, 3'd6, 32'h66, 8'h00, 1, 8'h00, 16'd0, 3'd6, 32'h0), "midrst");
        step(mk(0, 0, 3'd1, 32'h0, 8'h00, 1, 8'h00, 16'd0, 3'd1, 32'h0), "post1");
        step(mk(0, 0, 3'd4, 32'h0, 8'h00, 1, 8'h00, 16'd0, 3'd4, 32'h0), "post4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
